// File: rtl/sl_rx_fifo.sv
// Serial-line receiver: decodes the two-wire SL protocol into words of runtime length,
// checks odd parity and word length, and buffers good words in a valid/ready FIFO.
module sl_rx_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SAMPLE_POS = 8,
  parameter int unsigned IDLE_MIN   = 8,
  parameter int unsigned TOUT_CYC   = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sl_zeroes_a,
  input  logic              sl_ones_a,
  input  logic              cfg_en,
  input  logic [5:0]        cfg_word_len,
  input  logic              cfg_parity_en,
  input  logic              flush,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              busy,
  output logic              err_len,
  output logic              err_par,
  output logic              err_lvl,
  output logic              err_tout,
  output logic              err_ovf
);

  localparam int unsigned SH_W   = DATA_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned HI_MAX = (TOUT_CYC > IDLE_MIN) ? TOUT_CYC : IDLE_MIN;
  localparam int unsigned HI_W   = $clog2(HI_MAX + 1);
  localparam int unsigned CYC_W  = $clog2(SAMPLE_POS + 1);

  typedef enum logic [1:0] {StIdle, StSample, StWaitEnd} state_t;

  state_t            state_q, state_d;
  logic              z_meta, z_sync, o_meta, o_sync;
  logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [5:0]        len_q, len_d;
  logic              par_q, par_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic              both_high, start, strobe, bit_val;
  logic              e_len, e_par, e_lvl, e_tout, push;
  logic [5:0]        n_data;
  logic [SH_W-1:0]   data_mask;
  logic [DATA_W-1:0] push_data;

  // Synchronisers idle high so reset never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_meta <= 1'b1;
      z_sync <= 1'b1;
      o_meta <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      z_meta <= sl_zeroes_a;
      z_sync <= z_meta;
      o_meta <= sl_ones_a;
      o_sync <= o_meta;
    end
  end

  assign both_high = z_sync & o_sync;
  assign start     = cfg_en & ~both_high & (32'(hi_cnt_q) >= IDLE_MIN);
  assign strobe    = (state_q == StSample) && (32'(cycle_cnt_q) == SAMPLE_POS);
  assign bit_val   = ~o_sync;

  always_comb begin
    hi_cnt_d = '0;
    if (both_high) begin
      hi_cnt_d = (32'(hi_cnt_q) == HI_MAX) ? hi_cnt_q : hi_cnt_q + HI_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!cfg_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start) state_d = StSample;
        StSample:  if (strobe) state_d = StWaitEnd;
        StWaitEnd: if (32'(hi_cnt_q) >= IDLE_MIN) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Data bits kept on push: parity bit (last bit) is stripped when enabled.
  assign n_data    = par_q ? (len_q - 6'd1) : len_q;
  assign data_mask = (SH_W'(1) << n_data) - SH_W'(1);
  assign push_data = DATA_W'(shreg_q & data_mask);

  // Datapath and error decisions
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    len_d       = len_q;
    par_d       = par_q;
    push        = 1'b0;
    e_len       = 1'b0;
    e_par       = 1'b0;
    e_lvl       = 1'b0;
    e_tout      = 1'b0;
    if (!cfg_en) begin
      cycle_cnt_d = '0;
      bit_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cycle_cnt_d = CYC_W'(1);
            if (bit_cnt_q == '0) begin
              len_d = cfg_word_len;
              par_d = cfg_parity_en;
            end
          end else if (bit_cnt_q != '0 && 32'(hi_cnt_q) == TOUT_CYC) begin
            e_tout    = 1'b1;
            bit_cnt_d = '0;
          end
        end
        StSample: begin
          cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
          if (strobe) begin
            cycle_cnt_d = '0;
            if (z_sync ^ o_sync) begin
              if (bit_cnt_q == len_q) begin
                e_len     = 1'b1;
                bit_cnt_d = '0;
              end else begin
                // First bit of a word clears the previous word's leftovers.
                shreg_d   = ((bit_cnt_q == '0) ? '0 : shreg_q) | (SH_W'(bit_val) << bit_cnt_q);
                bit_cnt_d = bit_cnt_q + 6'd1;
              end
            end else if (!z_sync && !o_sync) begin
              if (bit_cnt_q != len_q)  e_len = 1'b1;
              else if (par_q && ~^shreg_q) e_par = 1'b1;
              else                     push  = 1'b1;
              bit_cnt_d = '0;
            end else begin
              e_lvl     = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt_q    <= '0;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      par_q       <= 1'b0;
      shreg_q     <= '0;
    end else begin
      hi_cnt_q    <= hi_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      par_q       <= par_d;
      shreg_q     <= shreg_d;
    end
  end

  assign busy = (bit_cnt_q != '0) || (state_q != StIdle);

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  count_q;
  logic              full, pop, do_push;

  assign full     = (32'(count_q) == FIFO_DEPTH);
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid & rx_ready;
  assign do_push  = push & ~flush & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + LVL_W'(do_push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign rx_data    = rx_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_len  <= 1'b0;
      err_par  <= 1'b0;
      err_lvl  <= 1'b0;
      err_tout <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_len  <= e_len;
      err_par  <= e_par;
      err_lvl  <= e_lvl;
      err_tout <= e_tout;
      err_ovf  <= push & ~flush & full & ~pop;
    end
  end

endmodule

// File: doc/sl_rx_fifo.md
Name: sl_rx_fifo

Overview:
- Parametrised next-generation serial-line (SL) receiver core.
- Decodes the two-wire SL protocol, assembles words of runtime-selectable length, checks parity and word length, and stores good words in an internal FIFO.
- The host side reads the FIFO through a valid/ready handshake.
- Sits behind the APB register shell. It replaces the fixed 8-sample, single-buffer receiver with a configurable, buffered one with timeout and overflow detection.

Parameters:
- DATA_W, 32, maximum data bits per word (8..32); width of rx_data.
- SAMPLE_POS, 8, clock cycles from start detection to the classification strobe.
- IDLE_MIN, 8, consecutive both-high cycles required to end a bit and re-arm start detection.
- TOUT_CYC, 1024, both-high cycles inside an unfinished word before the word is aborted.
- FIFO_DEPTH, 4, number of FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock (16 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- sl_zeroes_a  in  1  asynchronous SL zero line; idle high
- sl_ones_a  in  1  asynchronous SL ones line; idle high
- cfg_en  in  1  receiver enable
- cfg_word_len  in  6  bits per word including parity bit (8..DATA_W+1)
- cfg_parity_en  in  1  last bit before stop is an odd-parity bit
- flush  in  1  synchronous FIFO clear
- rx_data  out  DATA_W  FIFO head word, LSB = first received bit, zero-extended
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  host pops the head when rx_valid && rx_ready
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of stored words
- busy  out  1  word reception in progress (bit_cnt>0 or state≠IDLE)
- err_len, err_par, err_lvl, err_tout, err_ovf  out  1 each  one-cycle error pulses

Behaviour:
- Reset (rst high, async): state IDLE, counters 0, FIFO empty. rx_data=0, rx_valid=0, fifo_level=0, busy=0, all err_* = 0. Synchronisers preset high.
- Both SL lines pass through a 2-FF synchroniser; all decoding uses synchronised values, giving 2 cycles of latency.
- Start is detected when either synchronised line is low and the line-high run counter is ≥ IDLE_MIN. At the first start of a word, cfg_word_len and cfg_parity_en are latched; mid-word config changes are ignored.
- FSM states:
  - IDLE: on start → SAMPLE, cycle_cnt=1.
  - SAMPLE: cycle_cnt increments. When cycle_cnt==SAMPLE_POS, classify the lines:
    - zeroes low, ones high → bit 0.
    - ones low, zeroes high → bit 1.
    - both low → STOP.
    - both high → err_lvl, discard word.
    - After bit 0 or bit 1, go to WAIT_END.
  - Bit handling: shift the bit in at position bit_cnt and increment bit_cnt. If bit_cnt already equals the latched length, pulse err_len, discard the word and go to WAIT_END.
  - STOP checks:
    - bit_cnt ≠ latched length → err_len.
    - Otherwise, parity enabled and total ones (data+parity) even → err_par.
    - Otherwise push data bits [len-2:0] (parity enabled) or [len-1:0] into the FIFO.
    - bit_cnt is cleared in all three cases.
  - WAIT_END: return to IDLE once both lines have been high for IDLE_MIN cycles.
- Timeout: in IDLE with bit_cnt>0, a both-high run of TOUT_CYC cycles → err_tout pulse, bit_cnt=0, word discarded.
- Only one err_* pulse is raised per word; the pulse occurs on the strobe cycle +1.
- FIFO write: on the clock edge after the STOP strobe cycle; rx_valid is high from that edge.
  - A push into a full FIFO drops the word and pulses err_ovf.
  - Simultaneous push and pop on a full FIFO is accepted with no overflow.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored, the push is stored.
- Read pointers wrap modulo FIFO_DEPTH. rx_data is undefined-free: it is 0 when empty.
- flush: FIFO empty on the next edge; a push in the same cycle is discarded and raises no err_ovf. Reception state is unaffected.
- cfg_en low: FSM forced to IDLE, bit_cnt=0, partial word discarded silently, FIFO retained, no start accepted.
- rst mid-word: everything returns immediately to reset values.

Test Plan:
- Length 8, parity off; send 0xA5 LSB-first then STOP; host ready low → rx_valid rises one cycle after the STOP strobe, rx_data=0x000000A5, fifo_level=1, no err pulse.
- Length 9, parity on; send 0x03 with parity 1 → word 0x03 stored. Repeat with parity 0 → err_par pulse, fifo_level unchanged.
- Length 8; send 7 bits then STOP → err_len. Send 9 bits → err_len on the 9th bit strobe, no FIFO write.
- DEPTH 4, rx_ready low; send 5 words 0x11..0x55 → fifo_level=4, err_ovf on the 5th. Then pop all → 0x11, 0x22, 0x33, 0x44 in order, rx_valid drops after the 4th.
- Pulse the ones line low for only 3 cycles (lines high at the strobe) → err_lvl. Send 3 bits then hold both lines high for 1024 cycles → err_tout, busy falls.
- Length 32, parity off; send 0xDEADBEEF while rx_ready is held high continuously → word popped the cycle it appears, fifo_level returns to 0. Assert rst mid-word → all outputs 0 on the same cycle.
